sysid_checker: RTL

Avalon-MM read initiator that interrogates the system ID peripheral: on a start pulse it reads word 0 (system ID) and word 1 (build timestamp), compares both against expected values, and reports pass/fail/timeout. It sits on the HPS-to-FPGA lightweight fabric as a self-test master. Bring-up logic or an LED/status register can confirm the loaded bitstream matches the software image without CPU involvement.

---
 rtl/sysid_checker_if.sv | 35 +++
 rtl/sysid_checker.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sysid_checker_if.sv
// ---------------------------------------------------------------------------
// sysid_checker_if
//   Avalon-MM read-only bus between the system ID checker (master) and the
//   system ID peripheral (slave).
//
//   avm_address        word address (0 = system ID, 1 = build timestamp)
//   avm_read           read request, held until accepted
//   avm_waitrequest    slave stall; a read is accepted on an edge where
//                      avm_read=1 and avm_waitrequest=0
//   avm_readdatavalid  read data valid strobe
//   avm_readdata       32-bit read data
// ---------------------------------------------------------------------------
interface sysid_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdatavalid,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdatavalid,
        output avm_readdata
    );
endinterface

// File: rtl/sysid_checker.sv
// ---------------------------------------------------------------------------
// sysid_checker
//   Self-test Avalon-MM read master for the system ID peripheral. A start
//   pulse reads word 0 (system ID) then word 1 (build timestamp), compares
//   each against its expected value and reports the outcome. Every read
//   phase is bounded by TIMEOUT_CYCLES; an expired phase ends the check with
//   timeout=1.
//
//   clock     sole clock, rising edge
//   reset     synchronous, active-high
//   start     request a check (sampled only when idle or done)
//   avm       Avalon-MM master port (see sysid_checker_if)
//   busy      high while a check is in progress
//   done      one-cycle pulse when a check ends (pass, fail or timeout)
//   id_ok     captured ID equals EXPECTED_ID
//   ts_ok     captured timestamp equals EXPECTED_TIMESTAMP
//   timeout   check aborted by a phase timeout
//   id_value  captured ID word
//   ts_value  captured timestamp word
// ---------------------------------------------------------------------------
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd2899645186,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1400465847,
    parameter int unsigned TIMEOUT_CYCLES     = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    sysid_checker_if.master        avm,
    output logic                   busy,
    output logic                   done,
    output logic                   id_ok,
    output logic                   ts_ok,
    output logic                   timeout,
    output logic [31:0]            id_value,
    output logic [31:0]            ts_value
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        WAIT_ID,
        RD_TS,
        WAIT_TS,
        DONE
    } state_t;

    // Counter value on the last edge a phase may spend before it is aborted.
    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        read_q, read_d;
    logic        address_q, address_d;
    logic        busy_d, done_d, id_ok_d, ts_ok_d, timeout_d;
    logic [31:0] id_value_d, ts_value_d;
    logic        in_phase;
    logic        expired;
    logic        abort;

    assign avm.avm_read    = read_q;
    assign avm.avm_address = address_q;

    assign in_phase = (state_q == RD_ID) || (state_q == WAIT_ID) ||
                      (state_q == RD_TS) || (state_q == WAIT_TS);
    assign expired  = (cnt_q == LAST_CNT);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and infers a latch.
        state_d    = state_q;
        read_d     = 1'b0;
        address_d  = address_q;
        busy_d     = busy;
        done_d     = 1'b0;
        id_ok_d    = id_ok;
        ts_ok_d    = ts_ok;
        timeout_d  = timeout;
        id_value_d = id_value;
        ts_value_d = ts_value;
        abort      = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = RD_ID;
                    read_d     = 1'b1;
                    address_d  = 1'b0;
                    busy_d     = 1'b1;
                    id_ok_d    = 1'b0;
                    ts_ok_d    = 1'b0;
                    timeout_d  = 1'b0;
                    id_value_d = '0;
                    ts_value_d = '0;
                end
            end
            RD_ID, RD_TS: begin
                // read_q is always 1 here, so a low waitrequest is acceptance.
                if (!avm.avm_waitrequest) begin
                    state_d = (state_q == RD_ID) ? WAIT_ID : WAIT_TS;
                end else if (expired) begin
                    abort = 1'b1;
                end else begin
                    read_d = 1'b1;
                end
            end
            WAIT_ID: begin
                if (avm.avm_readdatavalid) begin
                    id_value_d = avm.avm_readdata;
                    id_ok_d    = (avm.avm_readdata == EXPECTED_ID);
                    state_d    = RD_TS;
                    read_d     = 1'b1;
                    address_d  = 1'b1;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            WAIT_TS: begin
                if (avm.avm_readdatavalid) begin
                    ts_value_d = avm.avm_readdata;
                    ts_ok_d    = (avm.avm_readdata == EXPECTED_TIMESTAMP);
                    state_d    = DONE;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Timeout: the uncaptured ok flag is already 0 from the start edge.
        if (abort) begin
            state_d   = DONE;
            read_d    = 1'b0;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            timeout_d = 1'b1;
        end

        // Phase counter restarts on every state change and only runs in a phase.
        cnt_d = (state_d != state_q || !in_phase) ? 16'd0 : cnt_q + 16'd1;
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge
    // values of the others, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            read_q    <= 1'b0;
            address_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            id_ok     <= 1'b0;
            ts_ok     <= 1'b0;
            timeout   <= 1'b0;
            id_value  <= '0;
            ts_value  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            read_q    <= read_d;
            address_q <= address_d;
            busy      <= busy_d;
            done      <= done_d;
            id_ok     <= id_ok_d;
            ts_ok     <= ts_ok_d;
            timeout   <= timeout_d;
            id_value  <= id_value_d;
            ts_value  <= ts_value_d;
        end
    end

endmodule
